rvc_fetch_aligner: RTL

- Sits between the instruction cache/memory fetch port and the ID stage.
- Accepts fetch blocks of FETCH_W bits into a halfword queue and realigns them into one instruction per cycle.
- Expands RVC instructions to their 32-bit equivalents.
- A 32-bit instruction that straddles two fetch blocks issues without a NOP bubble.
- Supports redirect/flush to any halfword-aligned PC.

---
 rtl/rvc_pkg.sv | 58 +++++
 rtl/rvc_expander.sv | 117 +++++++++++
 rtl/rvc_fetch_aligner.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rvc_pkg.sv
// Shared RV32 opcode/funct3 constants and instruction-format encoders
// used by the compressed-instruction expander and the fetch aligner.
package rvc_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    QUAD_C0   = 2'b00,
    QUAD_C1   = 2'b01,
    QUAD_C2   = 2'b10,
    QUAD_NONE = 2'b11
  } rvc_quadrant_e;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // Branch offset is always even, so only bits [12:1] are carried.
  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {7'b0000000, rs2, rs1, F3_ADD, rd, OP};
  endfunction

endpackage

// File: rtl/rvc_expander.sv
// Combinational RV32C-subset expander: one 16-bit parcel in, its 32-bit
// equivalent out; unsupported encodings give instr_o=0 and illegal_o=1.
module rvc_expander
  import rvc_pkg::*;
(
  input  logic [15:0] c_i,
  output logic [31:0] instr_o,
  output logic        illegal_o
);

  logic [4:0]  rd;
  logic [4:0]  rs2;
  logic [4:0]  rdp;
  logic [4:0]  rs2p;
  logic [11:0] imm6_sx;
  logic [11:0] lw_off;
  logic [12:1] b_off;
  logic [20:1] j_off;
  logic [11:0] shamt;

  // Operand and immediate fields, scattered per the compressed formats.
  always_comb begin
    rd      = c_i[11:7];
    rs2     = c_i[6:2];
    rdp     = {2'b01, c_i[9:7]};
    rs2p    = {2'b01, c_i[4:2]};
    imm6_sx = {{7{c_i[12]}}, c_i[6:2]};
    shamt   = {7'b0000000, c_i[6:2]};
    lw_off  = {5'b00000, c_i[5], c_i[12:10], c_i[6], 2'b00};
    b_off   = {{4{c_i[12]}}, c_i[12], c_i[6:5], c_i[2], c_i[11:10], c_i[4:3]};
    j_off   = {{9{c_i[12]}}, c_i[12], c_i[8], c_i[10:9], c_i[6], c_i[7], c_i[2],
               c_i[11], c_i[5:3]};
  end

  always_comb begin
    instr_o   = 32'h0000_0000;
    illegal_o = 1'b1;
    case (rvc_quadrant_e'(c_i[1:0]))
      QUAD_C0: begin
        case (c_i[15:13])
          3'b010: begin
            instr_o   = enc_i(lw_off, rdp, F3_LW, rs2p, LOAD);
            illegal_o = 1'b0;
          end
          3'b110: begin
            instr_o   = enc_s(lw_off, rs2p, rdp, F3_SW, STORE);
            illegal_o = 1'b0;
          end
          default: ;
        endcase
      end
      QUAD_C1: begin
        case (c_i[15:13])
          3'b000: begin
            instr_o   = enc_i(imm6_sx, rd, F3_ADD, rd, OP_IMM);
            illegal_o = 1'b0;
          end
          3'b001: begin
            instr_o   = enc_j(j_off, 5'd1);
            illegal_o = 1'b0;
          end
          3'b101: begin
            instr_o   = enc_j(j_off, 5'd0);
            illegal_o = 1'b0;
          end
          3'b100: begin
            // RV32 shifts with shamt[5] set are reserved.
            case (c_i[11:10])
              2'b00: if (!c_i[12]) begin
                instr_o   = enc_i(shamt, rdp, F3_SR, rdp, OP_IMM);
                illegal_o = 1'b0;
              end
              2'b01: if (!c_i[12]) begin
                instr_o   = enc_i(shamt | 12'h400, rdp, F3_SR, rdp, OP_IMM);
                illegal_o = 1'b0;
              end
              2'b10: begin
                instr_o   = enc_i(imm6_sx, rdp, F3_AND, rdp, OP_IMM);
                illegal_o = 1'b0;
              end
              default: ;
            endcase
          end
          3'b110: begin
            instr_o   = enc_b(b_off, 5'd0, rdp, F3_BEQ);
            illegal_o = 1'b0;
          end
          3'b111: begin
            instr_o   = enc_b(b_off, 5'd0, rdp, F3_BNE);
            illegal_o = 1'b0;
          end
          default: ;
        endcase
      end
      QUAD_C2: begin
        case (c_i[15:13])
          3'b000: if (!c_i[12]) begin
            instr_o   = enc_i(shamt, rd, F3_SLL, rd, OP_IMM);
            illegal_o = 1'b0;
          end
          3'b100: begin
            if (rs2 != 5'd0) begin
              instr_o   = enc_r(rs2, c_i[12] ? rd : 5'd0, rd);
              illegal_o = 1'b0;
            end else if (rd != 5'd0) begin
              instr_o   = enc_i(12'h000, rd, F3_ADD, c_i[12] ? 5'd1 : 5'd0, JALR);
              illegal_o = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Halfword queue between the fetch port and ID: realigns fetch blocks into
// one (expanded) instruction per cycle, including blocks straddled by 32-bit ops.
module rvc_fetch_aligner
  import rvc_pkg::*;
#(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic [31:0]        flush_pc_i,
  input  logic               fetch_valid_i,
  output logic               fetch_ready_o,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic [31:0]        instr_pc_o,
  output logic               instr_rvc_o,
  output logic               instr_illegal_o
);

  localparam int unsigned HW_PER_BLK = FETCH_W / 16;
  localparam int unsigned PTR_W      = $clog2(DEPTH_HW);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam int unsigned SKIP_W     = $clog2(HW_PER_BLK);

  logic [15:0]       mem_q [DEPTH_HW];
  logic [15:0]       mem_d [DEPTH_HW];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       pc_q, pc_d;
  logic [SKIP_W-1:0] skip_q, skip_d;

  logic [15:0]      hw0;
  logic [15:0]      hw1;
  logic             is32;
  logic [CNT_W-1:0] head_len;
  logic [CNT_W-1:0] push_len;
  logic             push;
  logic             pop;
  logic [31:0]      exp_instr;
  logic             exp_illegal;
  logic             unused_pc_bit0;

  assign unused_pc_bit0 = flush_pc_i[0];

  rvc_expander u_expander (
    .c_i       (hw0),
    .instr_o   (exp_instr),
    .illegal_o (exp_illegal)
  );

  // Head decode and the unregistered queue-to-output path.
  always_comb begin
    hw0      = mem_q[rd_ptr_q];
    hw1      = mem_q[rd_ptr_q + PTR_W'(1)];
    is32     = (hw0[1:0] == 2'b11);
    head_len = is32 ? CNT_W'(2) : CNT_W'(1);

    fetch_ready_o   = (CNT_W'(DEPTH_HW) - count_q) >= CNT_W'(HW_PER_BLK);
    instr_valid_o   = !flush_i && (count_q >= head_len);
    instr_pc_o      = pc_q;
    instr_rvc_o     = instr_valid_o && !is32;
    instr_illegal_o = instr_valid_o && !is32 && exp_illegal;
    if (!instr_valid_o)  instr_o = NOP;
    else if (is32)       instr_o = {hw1, hw0};
    else                 instr_o = exp_instr;
  end

  // Queue bookkeeping; a flush overrides any push or pop in the same cycle.
  always_comb begin
    push     = fetch_valid_i && fetch_ready_o && !flush_i;
    pop      = instr_valid_o && instr_ready_i;
    push_len = CNT_W'(HW_PER_BLK) - CNT_W'(skip_q);

    mem_d = mem_q;
    for (int unsigned k = 0; k < HW_PER_BLK; k++) begin
      if (push && (k >= 32'(skip_q)))
        mem_d[wr_ptr_q + PTR_W'(k) - PTR_W'(skip_q)] = fetch_data_i[16*k +: 16];
    end

    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(push_len) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(head_len) : PTR_W'(0));
    count_d  = count_q + (push ? push_len : CNT_W'(0)) - (pop ? head_len : CNT_W'(0));
    pc_d     = pop ? (pc_q + (is32 ? 32'd4 : 32'd2)) : pc_q;
    skip_d   = push ? SKIP_W'(0) : skip_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      pc_d     = {flush_pc_i[31:1], 1'b0};
      skip_d   = flush_pc_i[SKIP_W:1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= RESET_PC;
      skip_q   <= RESET_PC[SKIP_W:1];
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      skip_q   <= skip_d;
    end
  end

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
